// File: rtl/selen_wb_arb_pkg.sv
// Shared types and constants for the Selen two-port Wishbone arbiter.
package selen_wb_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  typedef enum logic {GNT_I, GNT_D} grant_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/selen_wb_arbiter_if.sv
// Wishbone classic master bus between the arbiter and the system interconnect.
interface selen_wb_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_W-1:0]     wb_adr_o;
  logic [DATA_W-1:0]     wb_dat_o;
  logic [DATA_W/8-1:0]   wb_sel_o;
  logic [DATA_W-1:0]     wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/selen_wb_arb_rr.sv
// Combinational round-robin picker for the I and D requesters.
module selen_wb_arb_rr
  import selen_wb_arb_pkg::*;
(
  input  logic   i_req_val,
  input  logic   d_req_val,
  input  grant_e last_grant,
  output logic   gnt_val,
  output grant_e gnt
);

  always_comb begin
    gnt_val = i_req_val | d_req_val;
    gnt     = GNT_I;
    if (i_req_val && d_req_val) gnt = (last_grant == GNT_D) ? GNT_I : GNT_D;
    else if (d_req_val)         gnt = GNT_D;
  end

endmodule

// File: rtl/selen_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic master between the Selen I and D ports.
// Optional bus watchdog: define SELEN_WB_ARB_TIMEOUT_EN.
module selen_wb_arbiter
  import selen_wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_val,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_req_ack,
  output logic [DATA_W-1:0]   i_ack_rdata,
  output logic                i_ack_err,
  input  logic                d_req_val,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_be,
  output logic                d_req_ack,
  output logic [DATA_W-1:0]   d_ack_rdata,
  output logic                d_ack_err,
  selen_wb_arbiter_if.master  wb
);

  localparam int unsigned SEL_W = DATA_W / 8;

  state_e              state_q, state_d;
  // Updated on every grant, so it also names the owner of the cycle in flight.
  grant_e              last_q, last_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                gnt_val;
  grant_e              gnt;

`ifdef SELEN_WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  selen_wb_arb_rr u_rr (
    .i_req_val  (i_req_val),
    .d_req_val  (d_req_val),
    .last_grant (last_q),
    .gnt_val    (gnt_val),
    .gnt        (gnt)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef SELEN_WB_ARB_TIMEOUT_EN
    err_d     = err_q;
    cnt_d     = (state_q == BUS) ? cnt_q + CNT_W'(1) : '0;
`endif
    case (state_q)
      IDLE: if (gnt_val) begin
        state_d = BUS;
        last_d  = gnt;
`ifdef SELEN_WB_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        if (gnt == GNT_I) begin
          adr_d = i_req_addr;
          dat_d = '0;
          sel_d = '1;
          we_d  = 1'b0;
        end else begin
          adr_d = d_req_addr;
          dat_d = d_req_wdata;
          sel_d = d_req_be;
          we_d  = d_req_we;
        end
      end
      BUS: if (wb.wb_ack_i) begin
        state_d = RESP;
        if (last_q == GNT_I) i_rdata_d = wb.wb_dat_i;
        else                 d_rdata_d = wb.wb_dat_i;
      end
`ifdef SELEN_WB_ARB_TIMEOUT_EN
      else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = RESP;
        err_d   = 1'b1;
        if (last_q == GNT_I) i_rdata_d = DATA_W'(TIMEOUT_RDATA);
        else                 d_rdata_d = DATA_W'(TIMEOUT_RDATA);
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= GNT_D;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign wb.wb_cyc_o = (state_q == BUS);
  assign wb.wb_stb_o = (state_q == BUS);
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;

  assign i_req_ack   = (state_q == RESP) && (last_q == GNT_I);
  assign d_req_ack   = (state_q == RESP) && (last_q == GNT_D);
  assign i_ack_rdata = i_rdata_q;
  assign d_ack_rdata = d_rdata_q;

`ifdef SELEN_WB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign i_ack_err = i_req_ack & err_q;
  assign d_ack_err = d_req_ack & err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign i_ack_err = 1'b0;
  assign d_ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_selen_wb_arbiter.sv
// Self-checking bench for selen_wb_arbiter: vector table, scoreboards and corner sequences.
module tb_selen_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_val, i_req_ack, i_ack_err;
  logic [31:0] i_req_addr, i_ack_rdata;
  logic        d_req_val, d_req_we, d_req_ack, d_ack_err;
  logic [31:0] d_req_addr, d_req_wdata, d_ack_rdata;
  logic [3:0]  d_req_be;

  always #5 clk = ~clk;

  selen_wb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) wb ();

  selen_wb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_val(i_req_val), .i_req_addr(i_req_addr), .i_req_ack(i_req_ack),
    .i_ack_rdata(i_ack_rdata), .i_ack_err(i_ack_err),
    .d_req_val(d_req_val), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ack(d_req_ack),
    .d_ack_rdata(d_ack_rdata), .d_ack_err(d_ack_err),
    .wb(wb.master)
  );

  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel;} wbx_t;
  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {
    logic port_d; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
    logic [31:0] srd; int lat;
    logic exp_we; logic [3:0] exp_sel; logic [31:0] exp_rdata; int exp_cyc;
  } vec_t;

  wbx_t wbq[$];
  rsp_t iq[$], dq[$];
  int   gapq[$], burstq[$];
  int   total = 0, bad = 0;

  // Slave model knobs
  logic        slv_en = 1'b1, slv_fixed = 1'b1, slv_inject = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          slv_lat = 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Wishbone slave: acks after slv_lat BUS cycles; data fixed or ~address.
  initial begin : slave
    int scnt;
    scnt = 0;
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (slv_inject) begin
        wb.wb_ack_i = 1'b1;
      end else if (slv_en && wb.wb_cyc_o && wb.wb_stb_o) begin
        if (scnt >= slv_lat - 1) begin
          wb.wb_ack_i = 1'b1;
          wb.wb_dat_i = slv_fixed ? slv_rdata : ~wb.wb_adr_o;
          scnt = 0;
        end else begin
          wb.wb_ack_i = 1'b0;
          scnt++;
        end
      end else begin
        wb.wb_ack_i = 1'b0;
        scnt = 0;
      end
    end
  end

  // Bus and response monitor with scoreboards.
  initial begin : mon
    logic cyc_prev;
    wbx_t cur, e;
    rsp_t r;
    int   hi, lo;
    cyc_prev = 1'b0; hi = 0; lo = 0;
    cur = '{1'b0, 32'h0, 32'h0, 4'h0};
    forever begin
      @(negedge clk);
      if (wb.wb_cyc_o) begin
        if (!cyc_prev) begin
          gapq.push_back(lo);
          lo = 0; hi = 0;
          cur = '{wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o};
          if (wbq.size() == 0) begin
            total++; bad++;
            $display("FAIL wb_unexpected_cycle actual_adr=%0h expected=none", cur.adr);
          end else begin
            e = wbq.pop_front();
            chk("wb_we", cur.we, e.we);
            chk("wb_adr", cur.adr, e.adr);
            chk("wb_sel", cur.sel, e.sel);
            if (e.we) chk("wb_dat", cur.dat, e.dat);
          end
        end else begin
          chk("wb_stable", {wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o},
              {cur.we, cur.adr, cur.dat, cur.sel});
        end
        chk("wb_stb", wb.wb_stb_o, 1'b1);
        hi++;
      end else begin
        if (cyc_prev) burstq.push_back(hi);
        lo++;
      end
      if (i_req_ack && d_req_ack) begin
        total++; bad++;
        $display("FAIL both_acks actual=11 expected=one_hot");
      end
      if (i_req_ack) begin
        if (iq.size() == 0) begin
          total++; bad++;
          $display("FAIL i_ack_unexpected actual_rdata=%0h expected=none", i_ack_rdata);
        end else begin
          r = iq.pop_front();
          chk("i_ack_rdata", i_ack_rdata, r.rdata);
          chk("i_ack_err", i_ack_err, r.err);
        end
      end
      if (d_req_ack) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL d_ack_unexpected actual_rdata=%0h expected=none", d_ack_rdata);
        end else begin
          r = dq.pop_front();
          chk("d_ack_rdata", d_ack_rdata, r.rdata);
          chk("d_ack_err", d_ack_err, r.err);
        end
      end
      cyc_prev = wb.wb_cyc_o;
    end
  end

  task automatic drive_i(input logic [31:0] a, output int n);
    i_req_addr = a;
    i_req_val  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_req_ack && n < 100);
    chk("i_ack_seen", i_req_ack, 1'b1);
    i_req_val = 1'b0;
  endtask

  task automatic drive_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output int n);
    d_req_we    = we;
    d_req_addr  = a;
    d_req_wdata = wd;
    d_req_be    = be;
    d_req_val   = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_req_ack && n < 100);
    chk("d_ack_seen", d_req_ack, 1'b1);
    d_req_val = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {i_req_ack, i_ack_rdata, i_ack_err, d_req_ack, d_ack_rdata, d_ack_err,
                       wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}, '0);
    chk({nm, "_bus"}, {wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o}, '0);
  endtask

  initial begin : main
    vec_t vt[6];
    vec_t v;
    int   c, c1, c2;

    //      port we addr          wdata         be      srd           lat we  sel     rdata         cyc
    vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0,   32'h0000_0013, 1, 1'b0, 4'hF,   32'h0000_0013, 2};
    vt[1] = '{1'b1, 1'b1, 32'h0001_0000, 32'hCAFE_F00D, 4'b0011, 32'h1234_5678, 1, 1'b1, 4'b0011, 32'h1234_5678, 2};
    vt[2] = '{1'b1, 1'b0, 32'h2000_0040, 32'h0,        4'hF,   32'hA5A5_5A5A, 3, 1'b0, 4'hF,   32'hA5A5_5A5A, 4};
    vt[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0,   32'hFFFF_FFFF, 2, 1'b0, 4'hF,   32'hFFFF_FFFF, 3};
    vt[4] = '{1'b1, 1'b0, 32'h2000_0044, 32'h0,        4'b1000, 32'h0000_0000, 5, 1'b0, 4'b1000, 32'h0000_0000, 6};
    vt[5] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,        4'h0,   32'h8000_0001, 5, 1'b0, 4'hF,   32'h8000_0001, 6};

    i_req_val = 1'b0; i_req_addr = '0;
    d_req_val = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_be = '0;

    #1 chk_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Both ports requesting from reset: I, D, I, D with two idle cycles between bursts
    slv_fixed = 1'b0; slv_lat = 1;
    gapq.delete();
    wbq.push_back('{1'b0, 32'h1000_0000, 32'h0, 4'hF});
    wbq.push_back('{1'b0, 32'h2000_0000, 32'h0, 4'hF});
    wbq.push_back('{1'b0, 32'h1000_0004, 32'h0, 4'hF});
    wbq.push_back('{1'b0, 32'h2000_0004, 32'h0, 4'hF});
    iq.push_back('{~32'h1000_0000, 1'b0});
    iq.push_back('{~32'h1000_0004, 1'b0});
    dq.push_back('{~32'h2000_0000, 1'b0});
    dq.push_back('{~32'h2000_0004, 1'b0});
    fork
      begin drive_i(32'h1000_0000, c1); drive_i(32'h1000_0004, c1); end
      begin drive_d(1'b0, 32'h2000_0000, 32'h0, 4'hF, c2); drive_d(1'b0, 32'h2000_0004, 32'h0, 4'hF, c2); end
    join
    repeat (2) @(negedge clk);
    chk("rr_bursts", gapq.size(), 4);
    for (int k = 1; k < 4; k++) chk("rr_gap", gapq[k], 2);

    // Acks injected while idle must be ignored
    slv_inject = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("inj_idle_cyc", wb.wb_cyc_o, 1'b0);
    end
    slv_inject = 1'b0;
    repeat (2) @(negedge clk);

    // Single transactions from the vector table
    for (int k = 0; k < 6; k++) begin
      v = vt[k];
      slv_fixed = 1'b1; slv_rdata = v.srd; slv_lat = v.lat;
      wbq.push_back('{v.exp_we, v.addr, v.wdata, v.exp_sel});
      if (v.port_d) begin
        dq.push_back('{v.exp_rdata, 1'b0});
        drive_d(v.we, v.addr, v.wdata, v.be, c);
      end else begin
        iq.push_back('{v.exp_rdata, 1'b0});
        drive_i(v.addr, c);
      end
      chk("req_to_ack", c, v.exp_cyc);
      @(negedge clk);
      chk("burst_len", burstq[$], v.lat);
    end

    // Reset while in BUS, then the first tie after reset goes to I
    slv_en = 1'b0;
    wbq.push_back('{1'b0, 32'h0000_0300, 32'h0, 4'hF});
    i_req_addr = 32'h0000_0300;
    i_req_val  = 1'b1;
    repeat (3) @(negedge clk);
    chk("bus_before_rst", wb.wb_cyc_o, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_bus_reset");
    i_req_val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    slv_en = 1'b1; slv_fixed = 1'b0; slv_lat = 1;
    wbq.push_back('{1'b0, 32'h0000_0400, 32'h0, 4'hF});
    wbq.push_back('{1'b1, 32'h0000_0500, 32'h1111_2222, 4'hC});
    iq.push_back('{~32'h0000_0400, 1'b0});
    dq.push_back('{~32'h0000_0500, 1'b0});
    fork
      begin drive_i(32'h0000_0400, c1); end
      begin drive_d(1'b1, 32'h0000_0500, 32'h1111_2222, 4'hC, c2); end
    join
    chk("tie_i_first", c1, 2);
    chk("tie_d_second", c2, 5);
    @(negedge clk);

`ifdef SELEN_WB_ARB_TIMEOUT_EN
    // Slave never acks: watchdog ends the cycle with an error response
    slv_en = 1'b0;
    wbq.push_back('{1'b0, 32'h0000_0600, 32'h0, 4'hF});
    dq.push_back('{32'hDEAD_BEEF, 1'b1});
    drive_d(1'b0, 32'h0000_0600, 32'h0, 4'hF, c);
    chk("to_latency", c, 9);
    @(negedge clk);
    chk("to_burst", burstq[$], 8);
    slv_en = 1'b1; slv_fixed = 1'b1; slv_rdata = 32'h7777_0001; slv_lat = 2;
    wbq.push_back('{1'b0, 32'h0000_0700, 32'h0, 4'hF});
    iq.push_back('{32'h7777_0001, 1'b0});
    drive_i(32'h0000_0700, c);
    chk("post_to_latency", c, 3);
`endif

    repeat (3) @(negedge clk);
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    chk("wbq_drained", wbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
